// File: rtl/issue_stage.sv
// Decodes the single buffered issue-queue entry and dispatches it atomically to the ROB and one EU.
// Latency: accept at N -> rob_valid_o at N+1; stalls hold the entry and drop issue_ready_o until it fires.
module issue_stage #(
  parameter int XLEN        = 64,
  parameter int ILEN        = 32,
  parameter int ROB_IDX_LEN = 3,
  parameter int NUM_EU      = 4,
  parameter int EXC_LEN     = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  logic [XLEN-1:0]        curr_pc_i,
  input  logic [ILEN-1:0]        instruction_i,
  input  logic [XLEN-1:0]        pred_target_i,
  input  logic                   pred_taken_i,
  input  logic                   except_raised_i,
  input  logic [EXC_LEN-1:0]     except_code_i,
  output logic                   rob_valid_o,
  input  logic                   rob_ready_i,
  input  logic [ROB_IDX_LEN-1:0] rob_tail_idx_i,
  output logic                   rob_except_raised_o,
  output logic [EXC_LEN-1:0]     rob_except_code_o,
  output logic [NUM_EU-1:0]      eu_valid_o,
  input  logic [NUM_EU-1:0]      eu_ready_i,
  output logic [XLEN-1:0]        dsp_pc_o,
  output logic [ILEN-1:0]        dsp_instr_o,
  output logic [XLEN-1:0]        dsp_pred_target_o,
  output logic                   dsp_pred_taken_o,
  output logic [ROB_IDX_LEN-1:0] dsp_rob_idx_o
);

  localparam int EU_IDX_W = $clog2(NUM_EU);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [EU_IDX_W-1:0] EU_ALU    = EU_IDX_W'(0);
  localparam logic [EU_IDX_W-1:0] EU_MULDIV = EU_IDX_W'(1);
  localparam logic [EU_IDX_W-1:0] EU_BRANCH = EU_IDX_W'(2);
  localparam logic [EU_IDX_W-1:0] EU_LSU    = EU_IDX_W'(3);

  localparam logic [EXC_LEN-1:0] EXC_ILLEGAL = EXC_LEN'(2);
  localparam logic [EXC_LEN-1:0] EXC_BREAK   = EXC_LEN'(3);
  localparam logic [EXC_LEN-1:0] EXC_ECALL_M = EXC_LEN'(11);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [ILEN-1:0]    instr;
    logic [XLEN-1:0]    pred_target;
    logic               pred_taken;
    logic               except_raised;
    logic [EXC_LEN-1:0] except_code;
  } entry_t;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state_q, state_d;
  entry_t              entry_q;
  logic                accept, fire;
  logic                dec_exc;
  logic [EXC_LEN-1:0]  dec_code;
  logic [EU_IDX_W-1:0] dec_unit;
  logic                entry_exc;
  logic [6:0]          opcode;
  logic [6:0]          funct7;

  assign opcode = entry_q.instr[6:0];
  assign funct7 = entry_q.instr[31:25];

  always_comb begin
    dec_exc  = 1'b0;
    dec_code = EXC_ILLEGAL;
    dec_unit = EU_ALU;
    if (entry_q.instr[1:0] != 2'b11) begin
      dec_exc = 1'b1;
    end else begin
      case (opcode)
        OPC_OP:        dec_unit = (funct7 == 7'b0000001) ? EU_MULDIV : EU_ALU;
        OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32,
        OPC_LUI, OPC_AUIPC, OPC_MISC_MEM:
                       dec_unit = EU_ALU;
        OPC_BRANCH, OPC_JAL, OPC_JALR:
                       dec_unit = EU_BRANCH;
        OPC_LOAD, OPC_STORE:
                       dec_unit = EU_LSU;
        OPC_SYSTEM: begin
          dec_exc = 1'b1;
          if (entry_q.instr == 32'h0000_0073)      dec_code = EXC_ECALL_M;
          else if (entry_q.instr == 32'h0010_0073) dec_code = EXC_BREAK;
          else                                     dec_code = EXC_ILLEGAL;
        end
        default:       dec_exc = 1'b1;
      endcase
    end
  end

  // A fetch-time exception outranks anything found by decode.
  assign entry_exc           = entry_q.except_raised | dec_exc;
  assign rob_except_raised_o = entry_exc;
  assign rob_except_code_o   = entry_q.except_raised ? entry_q.except_code : dec_code;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    rob_valid_o   = 1'b0;
    eu_valid_o    = '0;
    fire          = 1'b0;
    issue_ready_o = 1'b0;
    accept        = 1'b0;
    if (state_q == FULL) begin
      rob_valid_o = 1'b1;
      if (!entry_exc) eu_valid_o[dec_unit] = 1'b1;
      fire = rob_ready_i && (entry_exc || eu_ready_i[dec_unit]);
    end
    issue_ready_o = !flush_i && ((state_q == EMPTY) || fire);
    accept        = issue_valid_i && issue_ready_o;
    if (flush_i)     state_d = EMPTY;
    else if (accept) state_d = FULL;
    else if (fire)   state_d = EMPTY;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q <= '0;
    end else if (accept) begin
      entry_q.pc            <= curr_pc_i;
      entry_q.instr         <= instruction_i;
      entry_q.pred_target   <= pred_target_i;
      entry_q.pred_taken    <= pred_taken_i;
      entry_q.except_raised <= except_raised_i;
      entry_q.except_code   <= except_code_i;
    end
  end

  assign dsp_pc_o          = entry_q.pc;
  assign dsp_instr_o       = entry_q.instr;
  assign dsp_pred_target_o = entry_q.pred_target;
  assign dsp_pred_taken_o  = entry_q.pred_taken;
  assign dsp_rob_idx_o     = rob_tail_idx_i;

endmodule

// File: tb/tb_issue_stage.sv
// Scoreboard bench for issue_stage: directed test-plan sequences followed by randomized traffic.
module tb_issue_stage;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  logic [63:0] curr_pc_i = '0;
  logic [31:0] instruction_i = '0;
  logic [63:0] pred_target_i = '0;
  logic        pred_taken_i = 1'b0;
  logic        except_raised_i = 1'b0;
  logic [4:0]  except_code_i = '0;
  logic        rob_valid_o;
  logic        rob_ready_i = 1'b1;
  logic [2:0]  rob_tail_idx_i = '0;
  logic        rob_except_raised_o;
  logic [4:0]  rob_except_code_o;
  logic [3:0]  eu_valid_o;
  logic [3:0]  eu_ready_i = 4'hF;
  logic [63:0] dsp_pc_o;
  logic [31:0] dsp_instr_o;
  logic [63:0] dsp_pred_target_o;
  logic        dsp_pred_taken_o;
  logic [2:0]  dsp_rob_idx_o;

  always #5 clk = ~clk;

  issue_stage dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .curr_pc_i(curr_pc_i), .instruction_i(instruction_i),
    .pred_target_i(pred_target_i), .pred_taken_i(pred_taken_i),
    .except_raised_i(except_raised_i), .except_code_i(except_code_i),
    .rob_valid_o(rob_valid_o), .rob_ready_i(rob_ready_i),
    .rob_tail_idx_i(rob_tail_idx_i),
    .rob_except_raised_o(rob_except_raised_o), .rob_except_code_o(rob_except_code_o),
    .eu_valid_o(eu_valid_o), .eu_ready_i(eu_ready_i),
    .dsp_pc_o(dsp_pc_o), .dsp_instr_o(dsp_instr_o),
    .dsp_pred_target_o(dsp_pred_target_o), .dsp_pred_taken_o(dsp_pred_taken_o),
    .dsp_rob_idx_o(dsp_rob_idx_o)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    logic [63:0] tgt;
    bit          taken;
    bit          exc;
    logic [4:0]  code;
    int          unit;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_mode = 0;
  bit   zero_chk = 0;

  // Reference: which unit / exception an instruction should produce.
  function automatic exp_t model(input logic [31:0] ins, input bit exc_in, input logic [4:0] code_in);
    exp_t r;
    logic [6:0] op;
    op = ins[6:0];
    r.pc = '0; r.ins = ins; r.tgt = '0; r.taken = 0;
    r.exc = 0; r.code = 5'd0; r.unit = 0;
    if (ins[1:0] != 2'b11) begin
      r.exc = 1; r.code = 5'd2;
    end else begin
      case (op)
        7'h33: r.unit = (ins[31:25] == 7'h01) ? 1 : 0;
        7'h13, 7'h1B, 7'h3B, 7'h37, 7'h17, 7'h0F: r.unit = 0;
        7'h63, 7'h67, 7'h6F: r.unit = 2;
        7'h03, 7'h23: r.unit = 3;
        7'h73: begin
          r.exc = 1;
          if (ins == 32'h0000_0073)      r.code = 5'd11;
          else if (ins == 32'h0010_0073) r.code = 5'd3;
          else                           r.code = 5'd2;
        end
        default: begin r.exc = 1; r.code = 5'd2; end
      endcase
    end
    if (exc_in) begin r.exc = 1; r.code = code_in; end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard head every cycle.
  exp_t       head;
  bit         m_full, m_fire, m_ready;
  logic [3:0] m_eu;
  always @(negedge clk) begin
    if (rst_i) begin
      exp_q.delete();
      zero_chk = 1;
    end else begin
      if (zero_chk) begin
        chk("reset_pc", dsp_pc_o, 64'd0);
        chk("reset_instr", 64'(dsp_instr_o), 64'd0);
        chk("reset_target", dsp_pred_target_o, 64'd0);
        chk("reset_taken", 64'(dsp_pred_taken_o), 64'd0);
        zero_chk = 0;
      end
      m_full = exp_q.size() != 0;
      m_fire = 0;
      m_eu   = 4'b0000;
      if (m_full) begin
        head   = exp_q[0];
        m_fire = rob_ready_i && (head.exc || eu_ready_i[head.unit]);
        if (!head.exc) m_eu = 4'b0001 << head.unit;
        chk("pc", dsp_pc_o, head.pc);
        chk("instr", 64'(dsp_instr_o), 64'(head.ins));
        chk("target", dsp_pred_target_o, head.tgt);
        chk("taken", 64'(dsp_pred_taken_o), 64'(head.taken));
        chk("except_raised", 64'(rob_except_raised_o), 64'(head.exc));
        if (head.exc) chk("except_code", 64'(rob_except_code_o), 64'(head.code));
      end
      m_ready = !flush_i && (!m_full || m_fire);
      chk("rob_valid", 64'(rob_valid_o), 64'(m_full));
      chk("eu_valid", 64'(eu_valid_o), 64'(m_eu));
      chk("issue_ready", 64'(issue_ready_o), 64'(m_ready));
      chk("rob_idx", 64'(dsp_rob_idx_o), 64'(rob_tail_idx_i));
      if (flush_i)     exp_q.delete();
      else if (m_fire) void'(exp_q.pop_front());
    end
  end

  task automatic rand_ctrl();
    rob_ready_i    = $urandom_range(0, 3) != 0;
    eu_ready_i     = 4'($urandom);
    flush_i        = $urandom_range(0, 24) == 0;
    rob_tail_idx_i = 3'($urandom);
  endtask

  // Present one instruction and hold it until accepted; the expectation is queued on accept.
  task automatic send(input logic [31:0] ins, input bit exc, input logic [4:0] code);
    exp_t e;
    bit   done;
    int   n;
    @(posedge clk); #1;
    issue_valid_i   = 1'b1;
    curr_pc_i       = {$urandom, $urandom};
    instruction_i   = ins;
    pred_target_i   = {$urandom, $urandom};
    pred_taken_i    = 1'($urandom);
    except_raised_i = exc;
    except_code_i   = code;
    rob_tail_idx_i  = 3'($urandom);
    if (rand_mode) rand_ctrl();
    e       = model(ins, exc, code);
    e.pc    = curr_pc_i;
    e.tgt   = pred_target_i;
    e.taken = pred_taken_i;
    done = 0;
    n = 0;
    while (!done) begin
      @(negedge clk); #1;
      if (issue_ready_o && !flush_i) begin
        exp_q.push_back(e);
        done = 1;
      end else if (n > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: instr %08h not accepted within 200 cycles", ins);
        done = 1;
      end else begin
        n++;
        @(posedge clk); #1;
        if (rand_mode) rand_ctrl();
      end
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
      issue_valid_i = 1'b0;
      if (rand_mode) rand_ctrl();
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int r;
    ins = $urandom;
    r = $urandom_range(0, 15);
    case (r)
      0:  begin ins[6:0] = 7'h33; if ($urandom_range(0, 1) == 1) ins[31:25] = 7'h01; end
      1:  ins[6:0] = 7'h13;
      2:  ins[6:0] = 7'h3B;
      3:  ins[6:0] = 7'h1B;
      4:  ins[6:0] = 7'h37;
      5:  ins[6:0] = 7'h17;
      6:  ins[6:0] = 7'h0F;
      7:  ins[6:0] = 7'h63;
      8:  ins[6:0] = 7'h6F;
      9:  ins[6:0] = 7'h67;
      10: ins[6:0] = 7'h03;
      11: ins[6:0] = 7'h23;
      12: ins[6:0] = 7'h73;
      13: ins = 32'h0000_0073;
      14: ins = 32'h0010_0073;
      default: ;
    endcase
    return ins;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    // add, all readies high
    send(32'h00B5_0533, 0, 5'd0);
    idle(2);

    // mul stalled on MULDIV for three cycles
    eu_ready_i = 4'b1101;
    send(32'h02B5_0533, 0, 5'd0);
    idle(3);
    @(posedge clk); #1 eu_ready_i = 4'b1111;
    idle(2);

    // back-to-back stream: beq, ld, jal, sd
    send(32'h00B5_0463, 0, 5'd0);
    send(32'h0005_3503, 0, 5'd0);
    send(32'h0080_00EF, 0, 5'd0);
    send(32'h00B5_3023, 0, 5'd0);
    idle(2);

    // exceptions
    send(32'h0000_0073, 0, 5'd0);
    send(32'hFFFF_FFFF, 0, 5'd0);
    send(32'h00B5_0533, 1, 5'd1);
    send(32'h0010_0073, 0, 5'd0);
    idle(2);

    // flush of a stalled entry, with a competing issue_valid_i
    rob_ready_i = 1'b0;
    send(32'h00B5_0533, 0, 5'd0);
    idle(1);
    @(posedge clk); #1;
    flush_i = 1'b1; issue_valid_i = 1'b1; instruction_i = 32'h40B5_0533;
    @(posedge clk); #1;
    flush_i = 1'b0; issue_valid_i = 1'b0;
    idle(2);

    // reset while full and stalled
    send(32'h0005_3503, 0, 5'd0);
    idle(1);
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    rob_ready_i = 1'b1;
    idle(2);

    // randomized traffic
    rand_mode = 1;
    repeat (300) begin
      send(rand_instr(), $urandom_range(0, 7) == 0, 5'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(10);
    rand_mode = 0;
    @(posedge clk); #1;
    issue_valid_i = 1'b0; flush_i = 1'b0; rob_ready_i = 1'b1; eu_ready_i = 4'hF;
    idle(4);
    @(negedge clk); #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_stage.md
Name: issue_stage

Overview:
- Decodes the instruction popped from the issue queue and dispatches it to the reorder buffer (ROB) and to exactly one execution-unit reservation station.
- Sits directly downstream of the issue queue; consumes its valid/ready handshake and payload.
- Holds one registered entry (EMPTY/FULL) with full throughput; dispatch to ROB and EU is atomic in the same cycle.

Parameters:
- XLEN, 64, data/PC width (from len5_pkg)
- ILEN, 32, instruction width (from len5_pkg)
- ROB_IDX_LEN, 3, ROB index width (ROB depth 8)
- NUM_EU, 4, reservation stations; fixed mapping 0=ALU, 1=MULDIV, 2=BRANCH, 3=LSU

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  synchronous pipeline flush
- issue_valid_i  in  1  issue queue has an entry
- issue_ready_o  out  1  stage accepts entry this cycle
- curr_pc_i  in  XLEN  instruction PC
- instruction_i  in  ILEN  raw instruction
- pred_target_i  in  XLEN  predicted target
- pred_taken_i  in  1  predicted taken
- except_raised_i  in  1  fetch exception
- except_code_i  in  except_code_t  fetch exception code
- rob_valid_o  out  1  ROB allocation request
- rob_ready_i  in  1  ROB has a free slot
- rob_tail_idx_i  in  ROB_IDX_LEN  index ROB assigns on allocation
- rob_except_raised_o  out  1  entry carries an exception
- rob_except_code_o  out  except_code_t  exception code to ROB
- eu_valid_o  out  NUM_EU  one-hot dispatch request
- eu_ready_i  in  NUM_EU  reservation station free
- dsp_pc_o  out  XLEN  PC (shared by ROB and EUs)
- dsp_instr_o  out  ILEN  instruction
- dsp_pred_target_o  out  XLEN  predicted target
- dsp_pred_taken_o  out  1  predicted taken
- dsp_rob_idx_o  out  ROB_IDX_LEN  = rob_tail_idx_i, combinational passthrough

Behaviour:
- Reset (rst_i high at posedge): state EMPTY; all payload registers 0; rob_valid_o=0, eu_valid_o=0, issue_ready_o=1 from the next cycle. Reset overrides flush and handshakes.
- Decode runs on the registered entry, using opcode [6:0] and funct7 [31:25]:
  - OP with funct7=0000001 -> MULDIV.
  - OP (other funct7), OP-IMM, OP-32, OP-IMM-32, LUI, AUIPC, MISC-MEM -> ALU.
  - BRANCH, JAL, JALR -> BRANCH.
  - LOAD, STORE -> LSU.
  - SYSTEM: instr=0x00000073 -> exception code 11 (ecall M-mode); instr=0x00100073 -> code 3 (breakpoint); any other SYSTEM instruction -> code 2 (illegal).
  - Any other opcode, or instr[1:0]!=2'b11 -> code 2 (illegal).
- Exception priority: a latched except_raised_i wins over decode exceptions, and its except_code_i is passed unchanged.
- Exception entries are dispatched to the ROB only: eu_valid_o=0, rob_except_raised_o=1.
- FULL state:
  - rob_valid_o=1.
  - eu_valid_o is one-hot for the decoded unit (all-zero for an exception entry).
  - Fire condition: rob_ready_i && (exception || eu_ready_i[unit]).
  - rob_valid_o and eu_valid_o stay asserted and the payload stays stable until fire. ROB and EU see fire in the same cycle; a partial dispatch never occurs.
- EMPTY state: rob_valid_o=0, eu_valid_o=0; payload outputs hold their last value (don't-care).
- issue_ready_o = !flush_i && (EMPTY || fire).
- Accept = issue_valid_i && issue_ready_o; it loads the register and the state becomes/stays FULL.
- Fire without accept -> EMPTY.
- Latency: accept at cycle N -> rob_valid_o at N+1. Back-to-back fire and accept sustain 1 instruction/cycle.
- Flush: at the next edge, state -> EMPTY and the entry is discarded. issue_ready_o=0 during the flush cycle, and no accept occurs. An outstanding rob_valid_o/eu_valid_o in the flush cycle is still visible, but the ROB and EUs ignore it under flush.
- Payload registers are updated only on accept.

Test Plan:
- Reset, then issue_valid_i=1, instr=0x00B50533 (add), rob_ready_i=1, eu_ready_i=4'b1111 -> next cycle rob_valid_o=1, eu_valid_o=4'b0001, dsp_rob_idx_o=rob_tail_idx_i; fire that cycle.
- instr=0x02B50533 (mul) with eu_ready_i[1]=0 for 3 cycles -> eu_valid_o=4'b0010 and rob_valid_o held 3 cycles, issue_ready_o=0; fires on the cycle eu_ready_i[1] rises.
- Stream of 4 instructions (beq 0x00B50463, ld 0x00053503, jal 0x008000EF, sd 0x00B53023), all readies high -> eu_valid_o sequence 0100, 1000, 0100, 1000 on consecutive cycles, issue_ready_o constantly 1.
- ecall 0x00000073 -> eu_valid_o=0, rob_except_raised_o=1, code=11. Instr 0xFFFFFFFF -> code 2. except_raised_i=1 with code 1 on an add -> code 1, no EU request.
- Entry stalled on rob_ready_i=0, then flush_i=1 for 1 cycle -> next cycle rob_valid_o=0, eu_valid_o=0, issue_ready_o=1; an issue_valid_i during the flush cycle is not accepted.
- rst_i asserted while FULL and stalled -> next cycle all valids 0, payload registers 0, issue_ready_o=1.
